pr_ar_arbiter: RTL and testbench
================================

PR_AR_ARBITER -- requirements
Module: pr_ar_arbiter

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- NUM_SLICES, 4, number of prefetcher slices merged onto one DDR port.
- ADDR_BITS, 64, AR address width.
- BURST_LEN_WIDTH, 8, AR len width.
- TID_WIDTH, 8, AXI ID width.
- ORPHAN_LIMIT_WIDTH, 8, width of the orphan-beat timeout counter.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1, the single clock.
- reset, in, 1, synchronous, active-high reset.
- s_ar_valid, in, NUM_SLICES, per-slice AR valid.
- s_ar_ready, out, NUM_SLICES, per-slice AR ready.
- s_ar_addr, in, NUM_SLICES*ADDR_BITS, packed per-slice addresses; slice k occupies field k.
- s_ar_len, in, NUM_SLICES*BURST_LEN_WIDTH, packed per-slice burst lengths.
- s_ar_id, in, NUM_SLICES*TID_WIDTH, packed per-slice IDs.
- m_ar_valid, out, 1, DDR AR valid (registered).
- m_ar_ready, in, 1, DDR AR ready.
- m_ar_addr, out, ADDR_BITS, registered AR address.
- m_ar_len, out, BURST_LEN_WIDTH, registered AR len.
- m_ar_id, out, TID_WIDTH, registered AR ID.
- m_r_valid, in, 1, DDR R valid.
- m_r_id, in, TID_WIDTH, DDR R ID.
- m_r_ready, out, 1, DDR R ready.
- s_r_valid, out, NUM_SLICES, per-slice R valid (broadcast copy).
- s_r_id, out, TID_WIDTH, R ID broadcast to all slices.
- s_r_ready, in, NUM_SLICES, per-slice R ready.
- orphan_limit, in, ORPHAN_LIMIT_WIDTH, CR-space timeout; a value of 0 disables the timeout.
- err_r_conflict, out, 1, sticky flag: more than one slice was ready on a single beat.
- err_r_orphan, out, 1, sticky flag: a beat was dropped on timeout.
- orphan_drop, out, 1, one-cycle pulse when a beat is dropped.

Function
REQ-003 AR arbitration SHALL be round-robin over s_ar_valid:
- Search starts at slice rr_ptr, then rr_ptr+1, and so on, modulo NUM_SLICES.
- First valid slice found wins.
REQ-004 The output register SHALL be "loadable" when m_ar_valid==0 or (m_ar_valid & m_ar_ready).
REQ-005 When loadable and any s_ar_valid is set, the arbiter SHALL do the following in the same cycle:
- assert s_ar_ready[k] combinationally for the winner k only;
- capture addr, len and id of slice k into m_ar_* at the next edge;
- set m_ar_valid=1.
REQ-006 s_ar_ready SHALL be one-hot or zero, and SHALL be all-zero when not loadable or while reset=1.
REQ-007 After a grant to slice k, rr_ptr SHALL become (k+1) mod NUM_SLICES; with no grant, rr_ptr SHALL be unchanged.
REQ-008 Latency from s_ar handshake to m_ar_valid SHALL be exactly 1 cycle.
REQ-009 Throughput SHALL be one request per cycle while m_ar_ready stays high (back-to-back handshake and load in the same cycle).
REQ-010 While m_ar_valid & ~m_ar_ready, m_ar_valid, m_ar_addr, m_ar_len and m_ar_id SHALL hold stable.
REQ-011 On m_ar handshake with no new winner, m_ar_valid SHALL drop to 0 at the next edge.
REQ-012 No slice SHALL wait more than NUM_SLICES-1 grants to other slices while it holds s_ar_valid.
REQ-013 R path:
- s_r_valid[k] SHALL equal m_r_valid for all k.
- s_r_id SHALL equal m_r_id.
- m_r_ready SHALL equal (|s_r_ready) | orphan_drop.
REQ-014 When m_r_valid is set and two or more s_r_ready bits are set in one cycle, err_r_conflict SHALL set at the next edge and stay set until reset.
REQ-015 The orphan counter SHALL behave as follows:
- It increments each cycle that m_r_valid & ~|s_r_ready.
- It clears on any cycle where that condition is false.
- It saturates at its all-ones value.
REQ-016 When orphan_limit!=0 and the counter equals orphan_limit while m_r_valid & ~|s_r_ready:
- orphan_drop SHALL be high in that cycle (drops the beat);
- the counter SHALL clear;
- err_r_orphan SHALL set sticky.
REQ-017 orphan_limit==0 SHALL never generate orphan_drop.

Reset
REQ-018 Under reset=1 at a clock edge:
- m_ar_valid, err_r_conflict and err_r_orphan SHALL be 0;
- m_ar_addr, m_ar_len and m_ar_id SHALL be 0;
- rr_ptr SHALL be 0 and the orphan counter SHALL be 0.
REQ-019 During reset=1, s_ar_ready and orphan_drop SHALL be 0.
REQ-020 Reset mid-transaction SHALL drop a pending m_ar_valid without waiting for m_ar_ready.

Verification
REQ-021 Benches SHALL cover these scenarios:
- Post-reset, s_ar_valid=4'b1111, m_ar_ready=1 for 8 cycles -> grants go to slices 0,1,2,3,0,1,2,3, one per cycle; each m_ar_addr matches its granted slice one cycle later.
- Slice 2 requests with addr 0x1000, m_ar_ready=0 for 5 cycles -> m_ar_valid and m_ar_addr=0x1000 stay stable; no further s_ar_ready until the handshake; with slices 1 and 3 also valid, slice 3 wins next (rr_ptr=3).
- m_r_valid=1 with s_r_ready=4'b0100 -> m_r_ready=1 and no error flags; then s_r_ready=4'b0110 -> err_r_conflict=1 at the next edge and it stays set.
- orphan_limit=3, m_r_valid held with no slice ready -> orphan_drop pulses on the 4th cycle (counter==3); err_r_orphan=1; counter restarts at 0.
- orphan_limit=0, orphan beat held 300 cycles -> orphan_drop never asserts; counter saturates at 255.
- reset asserted while m_ar_valid=1 and m_ar_ready=0 -> m_ar_valid=0, rr_ptr=0 and flags cleared at the next edge.

Source files
------------

// File: rtl/pr_ar_arbiter.sv
// ---------------------------------------------------------------------------
// pr_ar_arbiter
//   Merges the AR channels of NUM_SLICES prefetcher slices onto one DDR AR
//   port using round-robin arbitration with a single registered output stage.
//   The R channel is broadcast back to every slice. It has two error monitors:
//   one flags beats claimed by several slices, and the other drops beats that
//   no slice accepts within a programmable timeout.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   s_ar_valid/ready    : per-slice AR handshake (ready is one-hot or zero)
//   s_ar_addr/len/id    : packed per-slice AR fields, slice k in field k
//   m_ar_valid/ready    : DDR AR handshake (valid is registered)
//   m_ar_addr/len/id    : registered DDR AR fields
//   m_r_valid/id/ready  : DDR R handshake
//   s_r_valid/id/ready  : per-slice R broadcast
//   orphan_limit        : orphan-beat timeout in cycles, 0 disables it
//   err_r_conflict      : sticky, several slices were ready on one beat
//   err_r_orphan        : sticky, a beat was dropped on timeout
//   orphan_drop         : one-cycle pulse when a beat is dropped
// ---------------------------------------------------------------------------
module pr_ar_arbiter #(
  parameter int NUM_SLICES         = 4,
  parameter int ADDR_BITS          = 64,
  parameter int BURST_LEN_WIDTH    = 8,
  parameter int TID_WIDTH          = 8,
  parameter int ORPHAN_LIMIT_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_SLICES-1:0]                 s_ar_valid,
  output logic [NUM_SLICES-1:0]                 s_ar_ready,
  input  logic [NUM_SLICES*ADDR_BITS-1:0]       s_ar_addr,
  input  logic [NUM_SLICES*BURST_LEN_WIDTH-1:0] s_ar_len,
  input  logic [NUM_SLICES*TID_WIDTH-1:0]       s_ar_id,
  output logic                                  m_ar_valid,
  input  logic                                  m_ar_ready,
  output logic [ADDR_BITS-1:0]                  m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
  output logic [TID_WIDTH-1:0]                  m_ar_id,
  input  logic                                  m_r_valid,
  input  logic [TID_WIDTH-1:0]                  m_r_id,
  output logic                                  m_r_ready,
  output logic [NUM_SLICES-1:0]                 s_r_valid,
  output logic [TID_WIDTH-1:0]                  s_r_id,
  input  logic [NUM_SLICES-1:0]                 s_r_ready,
  input  logic [ORPHAN_LIMIT_WIDTH-1:0]         orphan_limit,
  output logic                                  err_r_conflict,
  output logic                                  err_r_orphan,
  output logic                                  orphan_drop
);

  localparam int PTR_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  logic [PTR_W-1:0]              rr_ptr;
  logic [PTR_W-1:0]              grant_idx;
  logic                          grant_found;
  logic                          loadable;
  logic                          grant_fire;
  logic [ORPHAN_LIMIT_WIDTH-1:0] orphan_cnt;
  logic                          any_r_ready;
  logic                          multi_r_ready;
  logic                          orphan_cond;

  // The output register can take a new request when it is empty or its
  // current request is leaving this cycle, which gives back-to-back grants.
  assign loadable   = ~m_ar_valid | m_ar_ready;
  assign grant_fire = loadable & grant_found & ~reset;

  // Round-robin search: scan the slices starting at rr_ptr and wrap around.
  // The first slice found with valid set wins.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_SLICES) cand = cand - NUM_SLICES;
      if (!grant_found && s_ar_valid[PTR_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  assign s_ar_ready = grant_fire ? (NUM_SLICES'(1) << grant_idx) : '0;

  // AR output stage and arbitration pointer. When a grant fires, the stage
  // loads the winner's fields. When the held request leaves and there is no
  // new winner, the stage empties. In all other cycles it holds its contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_ar_valid <= 1'b0;
      m_ar_addr  <= '0;
      m_ar_len   <= '0;
      m_ar_id    <= '0;
      rr_ptr     <= '0;
    end else if (loadable) begin
      m_ar_valid <= grant_found;
      if (grant_found) begin
        m_ar_addr <= s_ar_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
        m_ar_len  <= s_ar_len[grant_idx*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
        m_ar_id   <= s_ar_id[grant_idx*TID_WIDTH +: TID_WIDTH];
        rr_ptr    <= (int'(grant_idx) == NUM_SLICES - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // R broadcast. Every slice sees the beat and is expected to claim it by ID.
  // If nobody claims the beat before the timeout, the beat is dropped.
  assign s_r_valid     = {NUM_SLICES{m_r_valid}};
  assign s_r_id        = m_r_id;
  assign any_r_ready   = |s_r_ready;
  // Clearing the lowest set bit leaves a nonzero value exactly when two or
  // more bits are set.
  assign multi_r_ready = |(s_r_ready & (s_r_ready - NUM_SLICES'(1)));
  assign orphan_cond   = m_r_valid & ~any_r_ready;
  assign orphan_drop   = ~reset & orphan_cond & (orphan_limit != '0) &
                         (orphan_cnt == orphan_limit);
  assign m_r_ready     = any_r_ready | orphan_drop;

  // The orphan counter measures how long the current beat has waited with no
  // slice ready. It saturates so that a disabled timeout cannot wrap around.
  always_ff @(posedge clk) begin
    if (reset) begin
      orphan_cnt     <= '0;
      err_r_conflict <= 1'b0;
      err_r_orphan   <= 1'b0;
    end else begin
      if (m_r_valid && multi_r_ready) err_r_conflict <= 1'b1;
      if (orphan_drop) begin
        orphan_cnt   <= '0;
        err_r_orphan <= 1'b1;
      end else if (orphan_cond) begin
        if (!(&orphan_cnt)) orphan_cnt <= orphan_cnt + 1'b1;
      end else begin
        orphan_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pr_ar_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pr_ar_arbiter
//   Self-checking bench for pr_ar_arbiter with the default parameters. A
//   reference model tracks the round-robin pointer, the output stage, the
//   orphan counter and the sticky flags. Each expected AR request is queued
//   when it is granted and compared with m_ar_* while it is presented.
// ---------------------------------------------------------------------------
module tb_pr_ar_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int LW = 8;
  localparam int IW = 8;
  localparam int OW = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [IW-1:0] id;
  } ar_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    s_ar_valid;
  logic [N-1:0]    s_ar_ready;
  logic [N*AW-1:0] s_ar_addr;
  logic [N*LW-1:0] s_ar_len;
  logic [N*IW-1:0] s_ar_id;
  logic            m_ar_valid;
  logic            m_ar_ready;
  logic [AW-1:0]   m_ar_addr;
  logic [LW-1:0]   m_ar_len;
  logic [IW-1:0]   m_ar_id;
  logic            m_r_valid;
  logic [IW-1:0]   m_r_id;
  logic            m_r_ready;
  logic [N-1:0]    s_r_valid;
  logic [IW-1:0]   s_r_id;
  logic [N-1:0]    s_r_ready;
  logic [OW-1:0]   orphan_limit;
  logic            err_r_conflict;
  logic            err_r_orphan;
  logic            orphan_drop;

  logic [AW-1:0] addr_v [N];
  logic [LW-1:0] len_v  [N];
  logic [IW-1:0] id_v   [N];

  // Reference model state
  ar_t exp_q[$];
  bit  model_valid;
  int  model_ptr;
  int  model_cnt;
  bit  model_cf;
  bit  model_orph;

  int passCount;
  int totalCount;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign s_ar_addr[g*AW +: AW] = addr_v[g];
    assign s_ar_len[g*LW +: LW]  = len_v[g];
    assign s_ar_id[g*IW +: IW]   = id_v[g];
  end

  pr_ar_arbiter dut (
    .clk(clk), .reset(reset),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_id(m_r_id), .m_r_ready(m_r_ready),
    .s_r_valid(s_r_valid), .s_r_id(s_r_id), .s_r_ready(s_r_ready),
    .orphan_limit(orphan_limit),
    .err_r_conflict(err_r_conflict), .err_r_orphan(err_r_orphan),
    .orphan_drop(orphan_drop)
  );

  // Counts a comparison and reports it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    totalCount++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    else
      passCount++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks every output against the model for the current inputs, then
  // advances the model and the DUT by one clock.
  task automatic applyStimulus();
    bit         loadable, found, cond, drop;
    int         win;
    logic [N-1:0] exp_ready;
    ar_t        item;
    #1;
    loadable = !model_valid || m_ar_ready;
    found    = 1'b0;
    win      = 0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (model_ptr + i) % N;
      if (!found && s_ar_valid[2'(k)] === 1'b1) begin
        found = 1'b1;
        win   = k;
      end
    end
    exp_ready = (!reset && loadable && found) ? N'(1 << win) : '0;
    checkOutput("s_ar_ready", 64'(s_ar_ready), 64'(exp_ready));
    checkOutput("m_ar_valid", 64'(m_ar_valid), 64'(model_valid));
    if (model_valid && exp_q.size() > 0) begin
      checkOutput("m_ar_addr", m_ar_addr, exp_q[0].addr);
      checkOutput("m_ar_len", 64'(m_ar_len), 64'(exp_q[0].len));
      checkOutput("m_ar_id", 64'(m_ar_id), 64'(exp_q[0].id));
    end

    cond = m_r_valid && (s_r_ready == '0);
    drop = !reset && cond && (orphan_limit != 0) && (model_cnt == int'(orphan_limit));
    checkOutput("orphan_drop", 64'(orphan_drop), 64'(drop));
    checkOutput("m_r_ready", 64'(m_r_ready), 64'((s_r_ready != '0) || drop));
    checkOutput("s_r_valid", 64'(s_r_valid), 64'({N{m_r_valid}}));
    checkOutput("s_r_id", 64'(s_r_id), 64'(m_r_id));
    checkOutput("err_r_conflict", 64'(err_r_conflict), 64'(model_cf));
    checkOutput("err_r_orphan", 64'(err_r_orphan), 64'(model_orph));

    if (reset) begin
      model_valid = 1'b0;
      model_ptr   = 0;
      model_cnt   = 0;
      model_cf    = 1'b0;
      model_orph  = 1'b0;
      exp_q.delete();
    end else begin
      if (model_valid && m_ar_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (loadable && found) begin
        item.addr = addr_v[win];
        item.len  = len_v[win];
        item.id   = id_v[win];
        exp_q.push_back(item);
        model_valid = 1'b1;
        model_ptr   = (win + 1) % N;
      end else if (loadable) begin
        model_valid = 1'b0;
      end
      if (m_r_valid && $countones(s_r_ready) >= 2) model_cf = 1'b1;
      if (drop) begin
        model_cnt  = 0;
        model_orph = 1'b1;
      end else if (cond) begin
        if (model_cnt < 255) model_cnt++;
      end else begin
        model_cnt = 0;
      end
    end
    tick();
  endtask

  initial begin
    passCount    = 0;
    totalCount   = 0;
    model_valid  = 1'b0;
    model_ptr    = 0;
    model_cnt    = 0;
    model_cf     = 1'b0;
    model_orph   = 1'b0;
    reset        = 1'b1;
    s_ar_valid   = '0;
    m_ar_ready   = 1'b0;
    m_r_valid    = 1'b0;
    m_r_id       = 8'h5A;
    s_r_ready    = '0;
    orphan_limit = '0;
    for (int k = 0; k < N; k++) begin
      addr_v[k] = '0;
      len_v[k]  = '0;
      id_v[k]   = '0;
    end
    tick();
    tick();
    s_ar_valid = 4'hF;
    m_ar_ready = 1'b1;
    applyStimulus();
    checkOutput("reset_m_ar_addr", m_ar_addr, 64'd0);
    reset      = 1'b0;
    s_ar_valid = '0;

    // All slices request back to back, so the grants rotate 0,1,2,3,0,...
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < N; k++) begin
        addr_v[k] = 64'hA000_0000 + 64'(c * 256 + k);
        len_v[k]  = 8'(k + c);
        id_v[k]   = 8'(16 * k + c);
      end
      s_ar_valid = 4'hF;
      m_ar_ready = 1'b1;
      applyStimulus();
    end
    s_ar_valid = '0;
    applyStimulus();
    applyStimulus();

    // Slice 2 is granted, and then the DDR port stalls for 5 cycles.
    addr_v[2]  = 64'h1000;
    len_v[2]   = 8'h07;
    id_v[2]    = 8'h22;
    addr_v[3]  = 64'h3000;
    len_v[3]   = 8'h03;
    id_v[3]    = 8'h33;
    addr_v[1]  = 64'h2000;
    s_ar_valid = 4'b0100;
    m_ar_ready = 1'b0;
    applyStimulus();
    s_ar_valid = 4'b1010;
    for (int c = 0; c < 5; c++) applyStimulus();
    m_ar_ready = 1'b1;
    applyStimulus();
    checkOutput("after_stall_addr", m_ar_addr, 64'h3000);
    s_ar_valid = '0;
    applyStimulus();
    applyStimulus();

    // R broadcast with a single ready slice, then a conflicting pair.
    m_r_valid = 1'b1;
    s_r_ready = 4'b0100;
    applyStimulus();
    s_r_ready = 4'b0110;
    applyStimulus();
    s_r_ready = 4'b0100;
    applyStimulus();
    applyStimulus();

    // Orphan timeout of 3 cycles: the drop comes on every fourth beat-cycle.
    orphan_limit = 8'd3;
    s_r_ready    = '0;
    for (int c = 0; c < 9; c++) applyStimulus();
    m_r_valid = 1'b0;
    applyStimulus();

    // Timeout disabled: the counter saturates. A limit of 255 then drops at once.
    orphan_limit = 8'd0;
    m_r_valid    = 1'b1;
    for (int c = 0; c < 300; c++) applyStimulus();
    orphan_limit = 8'd255;
    applyStimulus();
    applyStimulus();
    m_r_valid    = 1'b0;
    orphan_limit = 8'd0;
    applyStimulus();

    // Reset arrives while a request is stalled. After it, slice 0 wins first.
    addr_v[2]  = 64'hBEEF;
    s_ar_valid = 4'b0100;
    m_ar_ready = 1'b0;
    applyStimulus();
    s_ar_valid = '0;
    applyStimulus();
    reset      = 1'b1;
    s_ar_valid = 4'hF;
    applyStimulus();
    applyStimulus();
    checkOutput("mid_reset_m_ar_addr", m_ar_addr, 64'd0);
    reset      = 1'b0;
    m_ar_ready = 1'b1;
    applyStimulus();
    s_ar_valid = '0;
    applyStimulus();
    applyStimulus();

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
